sample_mix_router: RTL

Sample-rate and output-routing stage between the signal sources (generator / ADC path), the adaptive filter and the audio codec wrapper. Generates the filter's sample strobe from a parametrised divider, holds raw and filtered stereo samples, and switches between them with a click-free linear crossfade driven by a mode FSM. Results are presented to the codec buses on the codec's `ready` pulse, and a sticky error flags filter results that arrive late.

---
 rtl/sample_mix_router.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sample_mix_router.sv
// Sample strobe divider, raw/filtered sample holds and a linear crossfade mixer that feeds the
// codec buses on its ready pulse. A sticky flag records filter results that miss their interval.
module sample_mix_router #(
    parameter int unsigned W   = 24,
    parameter int unsigned DIV = 5000,
    parameter int unsigned F   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sel_i,
    input  logic [W-1:0] raw_l_i,
    input  logic [W-1:0] raw_r_i,
    input  logic [W-1:0] filt_l_i,
    input  logic [W-1:0] filt_r_i,
    input  logic         filt_valid_i,
    input  logic         ready_i,
    output logic         sample_o,
    output logic [W-1:0] l_out_o,
    output logic [W-1:0] r_out_o,
    output logic         out_valid_o,
    output logic         fading_o,
    output logic         late_err_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
    localparam logic [F:0] GMax = {1'b1, {F{1'b0}}};

    localparam logic [1:0] StRaw    = 2'd0;
    localparam logic [1:0] StFadeUp = 2'd1;
    localparam logic [1:0] StFilt   = 2'd2;
    localparam logic [1:0] StFadeDn = 2'd3;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sample_q, sample_d;
    logic [W-1:0]    raw_l_q, raw_r_q, filt_l_q, filt_r_q;
    logic            got_filt_q, got_filt_d;
    logic            first_q, first_d;
    logic            late_q, late_d;
    logic            sel_m_q, sel_s_q;
    logic [1:0]      state_q, state_d;
    logic [F:0]      g_q, g_d;
    logic [F:0]      g_up, g_dn;
    logic [W-1:0]    mix_l_q, mix_r_q;
    logic [W-1:0]    l_out_q, r_out_q;
    logic            out_valid_q;

    // (raw*(2^F-g) + filt*g) >>> F on a W+F+2 bit signed intermediate; floor, then truncate.
    function automatic logic [W-1:0] mix(input logic [W-1:0] raw, input logic [W-1:0] filt,
                                         input logic [F:0] g);
        logic signed [W+F+1:0] raw_x, filt_x, g_x, gr_x, acc;
        raw_x  = {{(F+2){raw[W-1]}}, raw};
        filt_x = {{(F+2){filt[W-1]}}, filt};
        g_x    = {{(W+1){1'b0}}, g};
        gr_x   = {{(W+1){1'b0}}, GMax - g};
        acc    = raw_x * gr_x + filt_x * g_x;
        return W'(acc >>> F);
    endfunction

    always_comb begin
        cnt_d    = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        sample_d = (cnt_q == CntMax);
    end

    always_comb begin
        got_filt_d = got_filt_q | filt_valid_i;
        first_d    = first_q;
        late_d     = late_q;
        if (sample_q) begin
            if (!first_q && !(got_filt_q || filt_valid_i)) begin
                late_d = 1'b1;
            end
            got_filt_d = 1'b0;
            first_d    = 1'b0;
        end
    end

    // Every state heads up while sel_s is set and down otherwise; RAW and FILT simply saturate.
    always_comb begin
        g_up    = (g_q == GMax) ? GMax : g_q + 1'b1;
        g_dn    = (g_q == '0) ? '0 : g_q - 1'b1;
        state_d = state_q;
        g_d     = g_q;
        if (sample_q) begin
            if (sel_s_q) begin
                g_d     = g_up;
                state_d = (g_up == GMax) ? StFilt : StFadeUp;
            end else begin
                g_d     = g_dn;
                state_d = (g_dn == '0) ? StRaw : StFadeDn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            sample_q    <= 1'b0;
            raw_l_q     <= '0;
            raw_r_q     <= '0;
            filt_l_q    <= '0;
            filt_r_q    <= '0;
            got_filt_q  <= 1'b0;
            first_q     <= 1'b1;
            late_q      <= 1'b0;
            sel_m_q     <= 1'b0;
            sel_s_q     <= 1'b0;
            state_q     <= StRaw;
            g_q         <= '0;
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            l_out_q     <= '0;
            r_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            if (sample_q) begin
                raw_l_q <= raw_l_i;
                raw_r_q <= raw_r_i;
            end
            if (filt_valid_i) begin
                filt_l_q <= filt_l_i;
                filt_r_q <= filt_r_i;
            end
            got_filt_q <= got_filt_d;
            first_q    <= first_d;
            late_q     <= late_d;
            sel_m_q    <= sel_i;
            sel_s_q    <= sel_m_q;
            state_q    <= state_d;
            g_q        <= g_d;
            mix_l_q    <= mix(raw_l_q, filt_l_q, g_q);
            mix_r_q    <= mix(raw_r_q, filt_r_q, g_q);
            if (ready_i) begin
                l_out_q <= mix_l_q;
                r_out_q <= mix_r_q;
            end
            out_valid_q <= ready_i;
        end
    end

    assign sample_o    = sample_q;
    assign l_out_o     = l_out_q;
    assign r_out_o     = r_out_q;
    assign out_valid_o = out_valid_q;
    assign fading_o    = (state_q == StFadeUp) || (state_q == StFadeDn);
    assign late_err_o  = late_q;

endmodule
